uart_work_receiver: RTL and testbench
=====================================

// Module: uart_work_receiver
// PURPOSE
//  Consumes the byte stream from the uart core's receive side (rxce/rx/frmero) and assembles framed
//  mining-work payloads (block header + target) for the hashing core. Validates each frame with an
//  XOR checksum and presents the payload as one wide word with a valid/ready handshake. Returns a
//  one-byte ACK/NAK to the host through the uart core's transmit side (txce/tx, gated by bsy).
// PARAMETERS
//  PAYLOAD_BYTES   80          payload bytes per frame (>=1)
//  TIMEOUT_CYCLES  5_000_000   max clock cycles between bytes inside a frame (100 ms @ 50 MHz)
// PORTS
//  clock       in   1                 system clock (50 MHz uart clock domain)
//  reset       in   1                 asynchronous, active-low reset
//  rxce        in   1                 1-cycle strobe: rx holds a received byte
//  rx          in   8                 received byte
//  frmero      in   1                 framing error on the byte strobed with rxce
//  bsy         in   1                 uart transmitter busy
//  txce        out  1                 1-cycle strobe: transmit tx
//  tx          out  8                 reply byte
//  work        out  PAYLOAD_BYTES*8   assembled payload; first received byte in bits [MSB -: 8]
//  work_valid  out  1                 work is stable and checksum-correct
//  work_ready  in   1                 consumer accepts work when work_valid && work_ready
//  overrun     out  1                 sticky: byte arrived while in DELIVER/REPLY and was dropped
//  err_count   out  8                 saturating count of rejected frames (bad chk/framing/timeout)
// BEHAVIOUR
//  Frame on wire: SYNC(8'hA5), PAYLOAD_BYTES payload bytes, CHK = XOR of all payload bytes.
//  Reset (async, active-low): state IDLE; txce=0, tx=8'h00, work=0, work_valid=0, overrun=0,
//   err_count=0, byte index=0, running checksum=0, timeout counter=0.
//  States and transitions (only on rxce unless stated):
//   IDLE    : byte==SYNC and !frmero -> PAYLOAD (index=0, chk=0). Other bytes ignored, no NAK.
//   PAYLOAD : store byte i at work[8*(PAYLOAD_BYTES-1-i) +: 8]; chk^=byte; after byte
//             PAYLOAD_BYTES-1 -> CHECK. A SYNC value here is data, not a restart.
//   CHECK   : byte==chk -> DELIVER, work_valid=1 next cycle; else -> REPLY(NAK).
//   DELIVER : work_valid held, work stable; on work_valid&&work_ready -> work_valid=0, REPLY(ACK).
//   REPLY   : wait while bsy; first cycle with !bsy: txce=1 for exactly one cycle, tx=ACK(8'h06)
//             or NAK(8'h15); next state IDLE. tx holds its value until the next reply.
//  Errors: rxce&&frmero in PAYLOAD/CHECK -> REPLY(NAK); in IDLE the byte is ignored.
//  Timeout: counter clears on every rxce, increments each cycle in PAYLOAD/CHECK; on reaching
//   TIMEOUT_CYCLES-1 -> REPLY(NAK). Counter idle (0) in other states.
//  Every NAK path increments err_count (saturates at 8'hFF, no wrap).
//  rxce in DELIVER or REPLY: byte dropped, overrun=1 (sticky until reset).
//  Simultaneous rxce and timeout expiry in the same cycle: the byte wins (counter clears).
//  Latency: last CHK byte strobe -> work_valid high 1 cycle later; handshake -> txce >=1 cycle later.
//  work keeps the last accepted payload after DELIVER; partially-written bytes of an aborted frame
//   may overwrite it, and work is meaningful only while work_valid=1.
//  Reset mid-frame or mid-DELIVER: all state discarded immediately, no reply sent.
// STRUCTURE
//  uart_frame_pkg: SYNC_BYTE, ACK_BYTE, NAK_BYTE constants; state encoding
//   (IDLE, PAYLOAD, CHECK, DELIVER, REPLY).
//  Sub-module uart_frame_timeout: parameterised down-counter (clear, enable, expired) for the
//   inter-byte watchdog. FSM, payload shift/index and reply logic stay in this module.
// TESTING (bench: PAYLOAD_BYTES=4, TIMEOUT_CYCLES=100, work_ready driven by bench)
//  1 A5 11 22 33 44 CHK=44, work_ready held high -> work=32'h11223344, work_valid 1 cycle after CHK,
//    one txce with tx=8'h06 once bsy=0.
//  2 A5 11 22 33 44 CHK=45 -> work_valid never rises; txce with tx=8'h15; err_count=1.
//  3 A5 11 22, then 100 idle cycles -> NAK sent, err_count=1; following clean frame accepted.
//  4 Good frame, work_ready=0 for 50 cycles while sending 3 extra bytes -> work_valid held,
//    work unchanged, overrun=1, ACK only after work_ready asserted.
//  5 A5 11 with frmero=1 on byte 2 -> NAK; bsy held high 20 cycles delays txce until bsy falls.
//  6 Reset asserted after A5 11 22 -> all outputs reset values, no txce; next clean frame accepted.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the uart work-frame receiver.
// Purpose : framing byte values (sync marker, ACK and NAK reply codes) and the
//           receiver state encoding.
// Ports   : none (package).
`timescale 1ns/1ps

package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    DELIVER,
    REPLY
  } frame_state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog for the work-frame receiver.
// Purpose : counts cycles without a received byte while enabled and flags
//           expiry once CYCLES-1 enabled cycles have elapsed since the last clear.
// Ports   :
//   clock    in  system clock
//   reset    in  asynchronous, active-low reset
//   clear    in  restart the interval (a byte arrived, or the watchdog is idle)
//   enable   in  count this cycle
//   expired  out interval used up
`timescale 1ns/1ps

module uart_frame_timeout #(
  parameter int CYCLES = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] remaining;

  // Holds the number of cycles left; a freshly loaded value means "zero cycles
  // elapsed", so reset and clear both load it. Saturates at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining <= LOAD;
    end else if (clear) begin
      remaining <= LOAD;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign expired = (remaining == '0);

endmodule

// File: rtl/uart_work_receiver.sv
// Mining-work frame receiver.
// Purpose : assembles SYNC + payload + XOR checksum frames from the uart
//           receive strobe into one wide work word, hands it over with a
//           valid/ready handshake and answers the host with ACK or NAK.
// Ports   :
//   clock       in  system clock
//   reset       in  asynchronous, active-low reset
//   rxce        in  strobe: rx holds a received byte
//   rx          in  received byte
//   frmero      in  framing error on the strobed byte
//   bsy         in  uart transmitter busy
//   txce        out strobe: transmit tx
//   tx          out reply byte (held until the next reply)
//   work        out assembled payload, first byte in the top bits
//   work_valid  out work is stable and checksum-correct
//   work_ready  in  consumer accepts work
//   overrun     out sticky: byte dropped while delivering or replying
//   err_count   out saturating count of rejected frames
`timescale 1ns/1ps

module uart_work_receiver
  import uart_frame_pkg::*;
#(
  parameter int PAYLOAD_BYTES  = 80,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rxce,
  input  logic [7:0]                 rx,
  input  logic                       frmero,
  input  logic                       bsy,
  output logic                       txce,
  output logic [7:0]                 tx,
  output logic [PAYLOAD_BYTES*8-1:0] work,
  output logic                       work_valid,
  input  logic                       work_ready,
  output logic                       overrun,
  output logic [7:0]                 err_count
);

  localparam int WORK_W = PAYLOAD_BYTES * 8;
  localparam int IDX_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  frame_state_t     state, next_state;
  logic [IDX_W-1:0] index, next_index;
  logic [7:0]       chk, next_chk;
  logic [WORK_W-1:0] next_work;
  logic             next_work_valid;
  logic             next_txce;
  logic [7:0]       next_tx;
  logic             next_overrun;
  logic [7:0]       next_err_count;
  logic             reply_nak, next_reply_nak;
  logic             go_nak;

  logic tmo_active;
  logic tmo_expired;
  logic timed_out;

  // The watchdog only runs while a frame is in flight; any byte restarts it,
  // and outside the frame it is held cleared so it starts fresh on the next one.
  assign tmo_active = (state == PAYLOAD) || (state == CHECK);

  uart_frame_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (rxce || !tmo_active),
    .enable  (tmo_active),
    .expired (tmo_expired)
  );

  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign timed_out = tmo_active && tmo_expired && !rxce;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      index      <= '0;
      chk        <= '0;
      work       <= '0;
      work_valid <= 1'b0;
      txce       <= 1'b0;
      tx         <= 8'h00;
      overrun    <= 1'b0;
      err_count  <= 8'h00;
      reply_nak  <= 1'b0;
    end else begin
      state      <= next_state;
      index      <= next_index;
      chk        <= next_chk;
      work       <= next_work;
      work_valid <= next_work_valid;
      txce       <= next_txce;
      tx         <= next_tx;
      overrun    <= next_overrun;
      err_count  <= next_err_count;
      reply_nak  <= next_reply_nak;
    end
  end

  // Next-state and output logic. Every rejection path funnels through go_nak so
  // the error counter and the NAK reply are always set together.
  always_comb begin
    next_state      = state;
    next_index      = index;
    next_chk        = chk;
    next_work       = work;
    next_work_valid = work_valid;
    next_txce       = 1'b0;
    next_tx         = tx;
    next_overrun    = overrun;
    next_err_count  = err_count;
    next_reply_nak  = reply_nak;
    go_nak          = 1'b0;

    case (state)
      IDLE: begin
        if (rxce && !frmero && (rx == SYNC_BYTE)) begin
          next_state = PAYLOAD;
          next_index = '0;
          next_chk   = '0;
        end
      end

      PAYLOAD: begin
        if (rxce) begin
          if (frmero) begin
            go_nak = 1'b1;
          end else begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
              if (int'(index) == i) begin
                next_work[8*(PAYLOAD_BYTES-1-i) +: 8] = rx;
              end
            end
            next_chk = chk ^ rx;
            if (index == LAST_IDX) begin
              next_state = CHECK;
            end else begin
              next_index = index + 1'b1;
            end
          end
        end else if (timed_out) begin
          go_nak = 1'b1;
        end
      end

      CHECK: begin
        if (rxce) begin
          if (!frmero && (rx == chk)) begin
            next_state      = DELIVER;
            next_work_valid = 1'b1;
          end else begin
            go_nak = 1'b1;
          end
        end else if (timed_out) begin
          go_nak = 1'b1;
        end
      end

      DELIVER: begin
        if (rxce) begin
          next_overrun = 1'b1;
        end
        if (work_valid && work_ready) begin
          next_work_valid = 1'b0;
          next_reply_nak  = 1'b0;
          next_state      = REPLY;
        end
      end

      REPLY: begin
        if (rxce) begin
          next_overrun = 1'b1;
        end
        if (!bsy) begin
          next_txce  = 1'b1;
          next_tx    = reply_nak ? NAK_BYTE : ACK_BYTE;
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    if (go_nak) begin
      next_state     = REPLY;
      next_reply_nak = 1'b1;
      if (err_count != 8'hFF) begin
        next_err_count = err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_work_receiver.sv
// Testbench for uart_work_receiver (4-byte payload, 100-cycle timeout).
// Purpose : drives directed frames and checks replies and delivered work
//           through expectation queues popped by a monitor.
// Ports   : none.
`timescale 1ns/1ps

module tb_uart_work_receiver;

  localparam int PB = 4;
  localparam int TC = 100;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rxce = 1'b0;
  logic [7:0]  rx = 8'h00;
  logic        frmero = 1'b0;
  logic        bsy = 1'b0;
  logic        work_ready = 1'b0;
  logic        txce;
  logic [7:0]  tx;
  logic [31:0] work;
  logic        work_valid;
  logic        overrun;
  logic [7:0]  err_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_work[$];
  logic        wv_prev = 1'b0;

  always #5 clock = ~clock;

  uart_work_receiver #(
    .PAYLOAD_BYTES  (PB),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rxce       (rxce),
    .rx         (rx),
    .frmero     (frmero),
    .bsy        (bsy),
    .txce       (txce),
    .tx         (tx),
    .work       (work),
    .work_valid (work_valid),
    .work_ready (work_ready),
    .overrun    (overrun),
    .err_count  (err_count)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every reply strobe and every rising work_valid must match the
  // oldest outstanding expectation; anything unannounced is an error.
  always @(negedge clock) begin
    if (txce === 1'b1) begin
      if (exp_tx.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_txce: got tx=%h, expected no reply", tx);
      end else begin
        check_output("reply_byte", 32'(tx), 32'(exp_tx.pop_front()));
      end
    end
    if ((work_valid === 1'b1) && !wv_prev) begin
      if (exp_work.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_work_valid: got work=%h, expected no delivery", work);
      end else begin
        check_output("work_word", work, exp_work.pop_front());
      end
    end
    wv_prev = (work_valid === 1'b1);
  end

  task automatic apply_stimulus(input logic [7:0] b, input logic fe);
    @(posedge clock);
    #1;
    rxce   = 1'b1;
    rx     = b;
    frmero = fe;
    @(posedge clock);
    #1;
    rxce   = 1'b0;
    frmero = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] data, input logic [7:0] chk);
    apply_stimulus(8'hA5, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      apply_stimulus(data[8*i +: 8], 1'b0);
    end
    apply_stimulus(chk, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rxce  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_reply(input string name);
    int n = 0;
    while ((exp_tx.size() != 0) && (n < 300)) begin
      @(posedge clock);
      n++;
    end
    #1;
    check_output(name, 32'(exp_tx.size()), 32'h0);
    exp_tx.delete();
  endtask

  task automatic check_reset_state(input string prefix);
    check_output({prefix, "_txce"}, 32'(txce), 32'h0);
    check_output({prefix, "_tx"}, 32'(tx), 32'h0);
    check_output({prefix, "_work"}, work, 32'h0);
    check_output({prefix, "_work_valid"}, 32'(work_valid), 32'h0);
    check_output({prefix, "_overrun"}, 32'(overrun), 32'h0);
    check_output({prefix, "_err_count"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    do_reset();
    check_reset_state("reset");

    // Test 1: clean frame, consumer always ready.
    work_ready = 1'b1;
    exp_work.push_back(32'h11223344);
    exp_tx.push_back(ACK);
    send_frame(32'h11223344, 8'h44);
    check_output("t1_valid_latency", 32'(work_valid), 32'h1);
    wait_reply("t1_ack_seen");
    repeat (5) @(posedge clock);
    #1;
    check_output("t1_tx_hold", 32'(tx), 32'h06);
    check_output("t1_err_count", 32'(err_count), 32'h0);

    // Test 2: wrong checksum.
    do_reset();
    exp_tx.push_back(NAK);
    send_frame(32'h11223344, 8'h45);
    check_output("t2_no_valid", 32'(work_valid), 32'h0);
    wait_reply("t2_nak_seen");
    check_output("t2_err_count", 32'(err_count), 32'h1);

    // Test 3: inter-byte timeout, then a clean frame.
    do_reset();
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(8'h11, 1'b0);
    apply_stimulus(8'h22, 1'b0);
    repeat (95) @(posedge clock);
    #1;
    check_output("t3_no_early_timeout", 32'(err_count), 32'h0);
    exp_tx.push_back(NAK);
    wait_reply("t3_nak_seen");
    check_output("t3_err_count", 32'(err_count), 32'h1);
    exp_work.push_back(32'h11223344);
    exp_tx.push_back(ACK);
    send_frame(32'h11223344, 8'h44);
    wait_reply("t3_ack_seen");

    // Test 4: consumer stalls while extra bytes arrive.
    work_ready = 1'b0;
    exp_work.push_back(32'hDEADBEEF);
    send_frame(32'hDEADBEEF, 8'h22);
    check_output("t4_valid_rise", 32'(work_valid), 32'h1);
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    apply_stimulus(8'h03, 1'b0);
    repeat (40) @(posedge clock);
    #1;
    check_output("t4_valid_held", 32'(work_valid), 32'h1);
    check_output("t4_work_stable", work, 32'hDEADBEEF);
    check_output("t4_overrun", 32'(overrun), 32'h1);
    check_output("t4_err_count", 32'(err_count), 32'h1);
    exp_tx.push_back(ACK);
    work_ready = 1'b1;
    wait_reply("t4_ack_seen");
    check_output("t4_valid_dropped", 32'(work_valid), 32'h0);

    // Test 5: framing error, reply delayed by a busy transmitter.
    do_reset();
    bsy = 1'b1;
    exp_tx.push_back(NAK);
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(8'h11, 1'b1);
    repeat (20) @(posedge clock);
    #1;
    check_output("t5_reply_held_by_bsy", 32'(exp_tx.size()), 32'h1);
    check_output("t5_err_count", 32'(err_count), 32'h1);
    bsy = 1'b0;
    wait_reply("t5_nak_seen");
    check_output("t5_tx_value", 32'(tx), 32'h15);

    // Test 6: reset in the middle of a frame.
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(8'h11, 1'b0);
    apply_stimulus(8'h22, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    check_reset_state("t6_midframe");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clock);
    exp_work.push_back(32'h01020304);
    exp_tx.push_back(ACK);
    send_frame(32'h01020304, 8'h04);
    wait_reply("t6_ack_seen");

    repeat (10) @(posedge clock);
    #1;
    check_output("end_tx_queue_empty", 32'(exp_tx.size()), 32'h0);
    check_output("end_work_queue_empty", 32'(exp_work.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
